// File: rtl/fpga_config_sequencer.sv
// Streams bitstream words into the eFPGA frame shift register, then fires the
// one-hot strobe-counter controls for each frame. Runs on the config clock.
module fpga_config_sequencer #(
    parameter int NUM_ROWS       = 6,
    parameter int FRAME_BITS_ROW = 32,
    parameter int NUM_COLS       = 8,
    parameter int MAX_FRAMES_COL = 36,
    parameter int STROBE_CYCLES  = 2
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      start,
    input  logic                      abort,
    input  logic [15:0]               cfg_frames,
    input  logic [FRAME_BITS_ROW-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      fd_shift,
    output logic                      fd_data,
    output logic                      rs_reset,
    output logic                      rs_incr,
    output logic                      rs_strobe,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [15:0]               frame_idx
);

    localparam int MAX_FRAMES = NUM_COLS * MAX_FRAMES_COL;
    localparam int BIT_W      = (FRAME_BITS_ROW > 1) ? $clog2(FRAME_BITS_ROW) : 1;
    localparam int ROW_W      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int STB_W      = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(FRAME_BITS_ROW - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(NUM_ROWS - 1);
    localparam logic [STB_W-1:0] STB_LAST     = STB_W'(STROBE_CYCLES - 1);
    localparam logic [15:0]      MAX_FRAMES_W = 16'(MAX_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_SHIFT,
        S_STROBE,
        S_INCR,
        S_DONE
    } state_t;

    state_t                    state;
    logic [FRAME_BITS_ROW-1:0] word_sr;
    logic [BIT_W-1:0]          bit_cnt;
    logic [ROW_W-1:0]          row_cnt;
    logic [STB_W-1:0]          stb_cnt;
    logic [15:0]               frames_cfg;

    // NOTE: every output is a register updated together with state, so each
    // branch assigns the output values that belong to the state being entered.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= S_IDLE;
            word_sr    <= '0;
            bit_cnt    <= '0;
            row_cnt    <= '0;
            stb_cnt    <= '0;
            frames_cfg <= '0;
            in_ready   <= 1'b0;
            fd_shift   <= 1'b0;
            fd_data    <= 1'b0;
            rs_reset   <= 1'b0;
            rs_incr    <= 1'b0;
            rs_strobe  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            frame_idx  <= '0;
        end else if (abort) begin
            // Abort truncates whatever is in flight; frame_idx keeps the committed count.
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            fd_shift  <= 1'b0;
            fd_data   <= 1'b0;
            rs_reset  <= 1'b0;
            rs_incr   <= 1'b0;
            rs_strobe <= 1'b0;
            busy      <= 1'b0;
            if (busy) error <= 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_CLR;
                        frames_cfg <= cfg_frames;
                        rs_reset   <= 1'b1;
                        frame_idx  <= '0;
                        row_cnt    <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                    end
                end
                S_CLR: begin
                    rs_reset <= 1'b0;
                    if (frames_cfg == 16'd0 || frames_cfg > MAX_FRAMES_W) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= (frames_cfg > MAX_FRAMES_W);
                    end else begin
                        state    <= S_LOAD;
                        in_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        state    <= S_SHIFT;
                        in_ready <= 1'b0;
                        fd_shift <= 1'b1;
                        fd_data  <= in_data[0];
                        word_sr  <= in_data >> 1;
                        bit_cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt == BIT_LAST) begin
                        fd_shift <= 1'b0;
                        fd_data  <= 1'b0;
                        if (row_cnt == ROW_LAST) begin
                            state     <= S_STROBE;
                            row_cnt   <= '0;
                            stb_cnt   <= '0;
                            rs_strobe <= 1'b1;
                        end else begin
                            state    <= S_LOAD;
                            row_cnt  <= row_cnt + ROW_W'(1);
                            in_ready <= 1'b1;
                        end
                    end else begin
                        fd_data <= word_sr[0];
                        word_sr <= word_sr >> 1;
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                S_STROBE: begin
                    if (stb_cnt == STB_LAST) begin
                        state     <= S_INCR;
                        rs_strobe <= 1'b0;
                        rs_incr   <= 1'b1;
                    end else begin
                        stb_cnt <= stb_cnt + STB_W'(1);
                    end
                end
                S_INCR: begin
                    rs_incr   <= 1'b0;
                    frame_idx <= frame_idx + 16'd1;
                    if (frame_idx + 16'd1 == frames_cfg) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= S_LOAD;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_config_sequencer.sv
// Bench for fpga_config_sequencer: random word streams checked against a model of
// the fabric frame register and strobe counter built from the source words.
module tb_fpga_config_sequencer;

    localparam int NUM_ROWS       = 6;
    localparam int FRAME_BITS_ROW = 32;
    localparam int STROBE_CYCLES  = 2;
    localparam int MAX_FRAMES     = 288;
    localparam int FRAME_LEN      = NUM_ROWS * FRAME_BITS_ROW;
    localparam int FRAME_CYCLES   = NUM_ROWS * (1 + FRAME_BITS_ROW) + STROBE_CYCLES + 1;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        start;
    logic        abort;
    logic [15:0] cfg_frames;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        fd_shift;
    logic        fd_data;
    logic        rs_reset;
    logic        rs_incr;
    logic        rs_strobe;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] frame_idx;

    fpga_config_sequencer dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .start     (start),
        .abort     (abort),
        .cfg_frames(cfg_frames),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fd_shift  (fd_shift),
        .fd_data   (fd_data),
        .rs_reset  (rs_reset),
        .rs_incr   (rs_incr),
        .rs_strobe (rs_strobe),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .frame_idx (frame_idx)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] src[$];
    int          widx;
    logic        snap_strobe;
    logic [15:0] snap_idx;

    // Fabric model: frame data register captured serially, strobe counter.
    int                   fstb_ctr = 0;
    int                   cap_cnt = 0;
    int                   n_shift = 0;
    int                   n_strobe_rise = 0;
    int                   n_strobe_cyc = 0;
    int                   n_incr = 0;
    int                   n_reset = 0;
    int                   strobe_run = 0;
    logic [FRAME_LEN-1:0] cap = '0;
    logic                 prev_strobe = 1'b0;
    logic                 rst_prev = 1'b0;
    logic                 abort_prev = 1'b0;

    function automatic logic [FRAME_LEN-1:0] expected_frame(input int f);
        logic [FRAME_LEN-1:0] v;
        v = '0;
        for (int r = 0; r < NUM_ROWS; r++)
            if (f * NUM_ROWS + r < src.size())
                v[r*FRAME_BITS_ROW +: FRAME_BITS_ROW] = src[f*NUM_ROWS+r];
        return v;
    endfunction

    always @(negedge wb_clk_i) begin
        n_cmp++;
        if ((int'(fd_shift) + int'(rs_strobe) + int'(rs_incr) + int'(rs_reset) > 1) ||
            (in_ready && fd_shift) ||
            (!busy && (fd_shift || rs_strobe || rs_incr || rs_reset || in_ready))) begin
            n_bad++;
            $display("FAIL ctrl_exclusive t=%0t got shift=%b strobe=%b incr=%b reset=%b ready=%b busy=%b, need one-hot-or-zero and idle when not busy",
                     $time, fd_shift, rs_strobe, rs_incr, rs_reset, in_ready, busy);
        end
        if (rst_prev) begin
            fstb_ctr = 0;
            cap_cnt  = 0;
        end
        if (rs_reset) begin
            n_reset++;
            fstb_ctr = 0;
            cap_cnt  = 0;
        end
        if (fd_shift) begin
            n_shift++;
            if (cap_cnt < FRAME_LEN) cap[cap_cnt] = fd_data;
            cap_cnt++;
        end
        if (rs_strobe) begin
            n_strobe_cyc++;
            strobe_run++;
            if (!prev_strobe) begin
                n_cmp++;
                if (cap_cnt != FRAME_LEN || cap !== expected_frame(fstb_ctr) || frame_idx !== 16'(fstb_ctr)) begin
                    n_bad++;
                    $display("FAIL frame_latch frame=%0d got bits=%0d idx=%0d data=%h, need bits=%0d idx=%0d data=%h",
                             fstb_ctr, cap_cnt, frame_idx, cap, FRAME_LEN, fstb_ctr, expected_frame(fstb_ctr));
                end
                n_strobe_rise++;
                cap_cnt = 0;
            end
        end else begin
            if (prev_strobe && !abort_prev && !rst_prev) begin
                n_cmp++;
                if (strobe_run != STROBE_CYCLES) begin
                    n_bad++;
                    $display("FAIL strobe_width got %0d cycles, need %0d", strobe_run, STROBE_CYCLES);
                end
            end
            strobe_run = 0;
        end
        if (rs_incr) begin
            n_incr++;
            fstb_ctr++;
        end
        prev_strobe = rs_strobe;
        rst_prev    = wb_rst_i;
        abort_prev  = abort;
    end

    task automatic clear_counts();
        n_shift       = 0;
        n_strobe_rise = 0;
        n_strobe_cyc  = 0;
        n_incr        = 0;
        n_reset       = 0;
    endtask

    task automatic fill_src(input int words);
        src.delete();
        for (int i = 0; i < words; i++) src.push_back($urandom);
    endtask

    // Starts a load and runs it until busy drops (done, abort or reset) or the budget expires.
    task automatic run_load(input int frames, input int stall_pct, input int abort_at,
                            input int restart_at, input int rst_at, input int budget,
                            output int busy_cycles);
        int   cycles;
        logic hs;
        logic timed_out;
        widx        = 0;
        cfg_frames  = 16'(frames);
        start       = 1'b1;
        @(posedge wb_clk_i); #1;
        start       = 1'b0;
        busy_cycles = 0;
        timed_out   = 1'b1;
        cycles      = 0;
        while (cycles < budget) begin
            abort    = (cycles + 1 == abort_at);
            start    = (cycles + 1 == restart_at);
            wb_rst_i = (cycles + 1 == rst_at);
            if (cycles + 1 == restart_at) cfg_frames = 16'd5;
            if (widx < src.size() && int'($urandom_range(99)) >= stall_pct) begin
                in_valid = 1'b1;
                in_data  = src[widx];
            end else begin
                in_valid = 1'b0;
                in_data  = $urandom;
            end
            @(negedge wb_clk_i);
            if (cycles + 1 == abort_at || cycles + 1 == rst_at) begin
                snap_strobe = rs_strobe;
                snap_idx    = frame_idx;
            end
            if (busy) busy_cycles++;
            else begin
                timed_out = 1'b0;
                break;
            end
            hs = in_valid && in_ready;
            @(posedge wb_clk_i); #1;
            if (hs) widx++;
            cycles++;
        end
        @(posedge wb_clk_i); #1;
        start    = 1'b0;
        abort    = 1'b0;
        wb_rst_i = 1'b0;
        in_valid = 1'b0;
        if (timed_out) begin
            n_cmp++;
            n_bad++;
            $display("FAIL load_timeout got busy after %0d cycles, need busy to drop", budget);
        end
    endtask

    task automatic test_reset();
        wb_rst_i   = 1'b1;
        start      = 1'b1;
        abort      = 1'b0;
        in_valid   = 1'b1;
        in_data    = 32'hdead_beef;
        cfg_frames = 16'd3;
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        n_cmp++;
        if ({in_ready, fd_shift, fd_data, rs_reset, rs_incr, rs_strobe, busy, done, error, frame_idx} !== 25'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got ready=%b shift=%b data=%b rst=%b incr=%b stb=%b busy=%b done=%b err=%b idx=%0d, need all 0",
                     in_ready, fd_shift, fd_data, rs_reset, rs_incr, rs_strobe, busy, done, error, frame_idx);
        end
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge wb_clk_i);
        n_cmp++;
        if (busy !== 1'b0 || rs_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release got busy=%b rs_reset=%b, need 0 0", busy, rs_reset);
        end
        @(posedge wb_clk_i); #1;
    endtask

    task automatic test_single_frame();
        int bc;
        src.delete();
        for (int i = 1; i <= NUM_ROWS; i++) src.push_back(32'(i));
        clear_counts();
        run_load(1, 0, 0, 0, 0, 1000, bc);
        n_cmp++; if (bc != FRAME_CYCLES + 1) begin n_bad++; $display("FAIL t1_cycles got %0d, need %0d", bc, FRAME_CYCLES + 1); end
        n_cmp++; if (done !== 1'b1 || error !== 1'b0) begin n_bad++; $display("FAIL t1_status got done=%b err=%b, need 1 0", done, error); end
        n_cmp++; if (frame_idx !== 16'd1) begin n_bad++; $display("FAIL t1_frame_idx got %0d, need 1", frame_idx); end
        n_cmp++; if (n_reset != 1) begin n_bad++; $display("FAIL t1_rs_reset got %0d cycles, need 1", n_reset); end
        n_cmp++; if (n_shift != FRAME_LEN) begin n_bad++; $display("FAIL t1_shift got %0d, need %0d", n_shift, FRAME_LEN); end
        n_cmp++; if (n_strobe_cyc != STROBE_CYCLES || n_strobe_rise != 1) begin n_bad++; $display("FAIL t1_strobe got %0d cycles %0d pulses, need %0d 1", n_strobe_cyc, n_strobe_rise, STROBE_CYCLES); end
        n_cmp++; if (n_incr != 1) begin n_bad++; $display("FAIL t1_incr got %0d, need 1", n_incr); end
        n_cmp++; if (widx != NUM_ROWS) begin n_bad++; $display("FAIL t1_words got %0d, need %0d", widx, NUM_ROWS); end
    endtask

    task automatic test_full_load();
        int bc;
        fill_src(MAX_FRAMES * NUM_ROWS);
        clear_counts();
        run_load(MAX_FRAMES, 0, 0, 0, 0, 60000, bc);
        n_cmp++; if (bc != MAX_FRAMES * FRAME_CYCLES + 1) begin n_bad++; $display("FAIL t2_cycles got %0d, need %0d", bc, MAX_FRAMES * FRAME_CYCLES + 1); end
        n_cmp++; if (done !== 1'b1 || error !== 1'b0) begin n_bad++; $display("FAIL t2_status got done=%b err=%b, need 1 0", done, error); end
        n_cmp++; if (frame_idx !== 16'(MAX_FRAMES) || fstb_ctr != MAX_FRAMES) begin n_bad++; $display("FAIL t2_frame_idx got %0d model %0d, need %0d", frame_idx, fstb_ctr, MAX_FRAMES); end
        n_cmp++; if (n_strobe_rise != MAX_FRAMES) begin n_bad++; $display("FAIL t2_frames got %0d, need %0d", n_strobe_rise, MAX_FRAMES); end
    endtask

    task automatic test_stall();
        int bc;
        fill_src(3 * NUM_ROWS);
        clear_counts();
        run_load(3, 40, 0, 100, 0, 5000, bc);
        n_cmp++; if (done !== 1'b1 || frame_idx !== 16'd3) begin n_bad++; $display("FAIL t3_status got done=%b idx=%0d, need 1 3", done, frame_idx); end
        n_cmp++; if (n_shift != 3 * FRAME_LEN) begin n_bad++; $display("FAIL t3_shift got %0d, need %0d", n_shift, 3 * FRAME_LEN); end
        n_cmp++; if (widx != 3 * NUM_ROWS) begin n_bad++; $display("FAIL t3_words got %0d, need %0d", widx, 3 * NUM_ROWS); end
        n_cmp++; if (n_reset != 1 || n_strobe_rise != 3) begin n_bad++; $display("FAIL t3_restart_ignored got resets=%0d frames=%0d, need 1 3", n_reset, n_strobe_rise); end
    endtask

    task automatic test_abort();
        int bc;
        int abort_cycle;
        abort_cycle = 1 + FRAME_CYCLES + NUM_ROWS * (1 + FRAME_BITS_ROW) + 2;
        fill_src(3 * NUM_ROWS);
        clear_counts();
        run_load(3, 0, abort_cycle, 0, 0, 2000, bc);
        n_cmp++; if (snap_strobe !== 1'b1 || snap_idx !== 16'd1) begin n_bad++; $display("FAIL t4_abort_point got strobe=%b idx=%0d, need 1 1", snap_strobe, snap_idx); end
        n_cmp++; if (busy !== 1'b0 || rs_strobe !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL t4_idle got busy=%b stb=%b done=%b, need 0 0 0", busy, rs_strobe, done); end
        n_cmp++; if (error !== 1'b1 || frame_idx !== 16'd1) begin n_bad++; $display("FAIL t4_error got err=%b idx=%0d, need 1 1", error, frame_idx); end
        n_cmp++; if (n_strobe_rise != 2 || n_incr != 1) begin n_bad++; $display("FAIL t4_progress got pulses=%0d incr=%0d, need 2 1", n_strobe_rise, n_incr); end
        fill_src(NUM_ROWS);
        clear_counts();
        run_load(1, 0, 0, 0, 0, 1000, bc);
        n_cmp++; if (n_reset != 1 || done !== 1'b1 || frame_idx !== 16'd1) begin n_bad++; $display("FAIL t4_reload got resets=%0d done=%b idx=%0d, need 1 1 1", n_reset, done, frame_idx); end
        n_cmp++; if (n_strobe_rise != 1 || n_shift != FRAME_LEN) begin n_bad++; $display("FAIL t4_reload_data got pulses=%0d shifts=%0d, need 1 %0d", n_strobe_rise, n_shift, FRAME_LEN); end
    endtask

    task automatic test_edge_counts();
        int bc;
        fill_src(NUM_ROWS);
        clear_counts();
        run_load(0, 0, 0, 0, 0, 100, bc);
        n_cmp++; if (bc != 1 || done !== 1'b1 || error !== 1'b0) begin n_bad++; $display("FAIL t5_zero got cycles=%0d done=%b err=%b, need 1 1 0", bc, done, error); end
        n_cmp++; if (n_shift != 0 || n_strobe_cyc != 0 || frame_idx !== 16'd0 || n_reset != 1) begin n_bad++; $display("FAIL t5_zero_quiet got shifts=%0d stb=%0d idx=%0d resets=%0d, need 0 0 0 1", n_shift, n_strobe_cyc, frame_idx, n_reset); end
        clear_counts();
        run_load(MAX_FRAMES + 1, 0, 0, 0, 0, 100, bc);
        n_cmp++; if (done !== 1'b1 || error !== 1'b1) begin n_bad++; $display("FAIL t5_range got done=%b err=%b, need 1 1", done, error); end
        n_cmp++; if (n_strobe_cyc != 0 || n_shift != 0 || widx != 0) begin n_bad++; $display("FAIL t5_range_quiet got stb=%0d shifts=%0d words=%0d, need 0 0 0", n_strobe_cyc, n_shift, widx); end
    endtask

    task automatic test_abort_start();
        int bc;
        fill_src(NUM_ROWS);
        clear_counts();
        run_load(1, 0, 0, 0, 0, 1000, bc);
        start = 1'b1;
        abort = 1'b1;
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        n_cmp++; if (busy !== 1'b0 || rs_reset !== 1'b0 || done !== 1'b1 || error !== 1'b0) begin n_bad++; $display("FAIL abort_wins got busy=%b rst=%b done=%b err=%b, need 0 0 1 0", busy, rs_reset, done, error); end
        @(posedge wb_clk_i); #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bc;
        fill_src(2 * NUM_ROWS);
        clear_counts();
        run_load(2, 0, 0, 0, FRAME_CYCLES + 50, 1000, bc);
        n_cmp++; if (snap_idx !== 16'd1) begin n_bad++; $display("FAIL rst_mid_before got idx=%0d, need 1", snap_idx); end
        n_cmp++; if ({busy, done, error, rs_strobe, fd_shift, in_ready, frame_idx} !== 22'd0) begin n_bad++; $display("FAIL rst_mid_after got busy=%b done=%b err=%b stb=%b shift=%b ready=%b idx=%0d, need all 0", busy, done, error, rs_strobe, fd_shift, in_ready, frame_idx); end
    endtask

    initial begin
        wb_rst_i   = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        cfg_frames = '0;
        test_reset();
        test_single_frame();
        test_full_load();
        test_stall();
        test_abort();
        test_edge_counts();
        test_abort_start();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
